ierl78_prtyerr_multi: RTL and testbench
=======================================

IERL78_PRTYERR_MULTI -- requirements
Module: ierl78_prtyerr_multi

Interface
REQ-001 The block SHALL have parameter NCH, default 2, giving the number of independent injection channels (legal 1..4).
REQ-002 The block SHALL have parameter AW, default 16, giving the CPU address width (legal 16..20).
REQ-003 BASECK  in  1  system clock; all state updates on its rising edge.
REQ-004 SYSRSOUTB  in  1  system reset, asynchronous, active-low.
REQ-005 MA  in  AW  CPU memory address.
REQ-006 CPURD  in  1  CPU read cycle qualifier.
REQ-007 SVMOD  in  1  supervisor/break mode; high blocks injection.
REQ-008 FCHRAM  in  1  fetch-from-RAM; high blocks injection.
REQ-009 ICEIFA  in  32  host I/F address.
REQ-010 ICEDI  in  16  host I/F write data.
REQ-011 ICEWR  in  1  host write strobe, synchronous to BASECK; one cycle high = one write.
REQ-012 ICEDOPB  out  32  host read data; combinational decode of ICEIFA; 0 for unmapped addresses.
REQ-013 RPERR  out  1  registered parity-error pulse to csc.

Function
REQ-014 Register map: ADRn at 0x0401_0000+8n (bits AW-1:0 RW, others read 0); CTLn at 0x0401_0004+8n; STAT at 0x0401_0100.
REQ-015 CTLn fields: [0] EN, [15:8] NUM (injections to perform, 0 = unlimited); other bits read 0.
REQ-016 STAT fields: [NCH-1:0] sticky HIT, write-1-to-clear; [NCH+7:8] DONE, read-only; writes to other bits ignored.
REQ-017 Each channel SHALL run an FSM with states IDLE, ARMED, DONE.
REQ-018 A CTLn write with EN=1 SHALL load REMn=NUM and enter ARMED from any state; a write with EN=0 SHALL enter IDLE.
REQ-019 hitn = ARMED & CPURD & ~SVMOD & ~FCHRAM & (MA == ADRn), evaluated every cycle.
REQ-020 On hitn: set HITn; if NUM≠0, decrement REMn; when REMn goes 1->0, enter DONE.
REQ-021 DONE SHALL ignore further hits until rearmed by a CTLn write; DONE bit = (state==DONE).
REQ-022 RPERR SHALL be high exactly the cycle after any hitn is true (OR of channels), one cycle per hit cycle; consecutive read cycles each count.
REQ-023 Channels sharing an address SHALL each count the same hit independently.
REQ-024 A host write to CTLn or ADRn in the same cycle as hitn SHALL take priority: no count, no HITn set, no RPERR contribution from channel n that cycle.
REQ-025 A STAT W1C write coinciding with hitn SHALL leave HITn set.
REQ-026 REMn SHALL be 8 bits and SHALL never underflow.

Reset
REQ-027 On SYSRSOUTB low: all ADRn, CTLn, REMn, HIT = 0; all FSMs IDLE; RPERR = 0; ICEDOPB follows decode of reset values.
REQ-028 Reset asserted mid-count SHALL abort immediately; no RPERR pulse after reset release without a new arm.

Configuration
REQ-029 Macro IERL78_PRTYERR_CNT_EN: defined -> NUM/REMn and DONE behave as above.
REQ-030 Without IERL78_PRTYERR_CNT_EN: no NUM/REMn storage, CTLn[15:8] reads 0, every armed channel is unlimited, DONE unreachable, STAT DONE bits read 0.

Verification
REQ-031 Arm ch0 ADR=0x1234, NUM=0; 3 consecutive CPURD cycles at MA=0x1234 -> RPERR high 3 cycles, each one cycle late; STAT=0x0001.
REQ-032 Arm ch1 NUM=2; 3 reads at match -> 2 RPERR pulses, ch1 DONE, STAT reads 0x0202 (NCH=2).
REQ-033 Matching reads with SVMOD=1, then FCHRAM=1 -> no RPERR, HIT stays 0.
REQ-034 CTL0 write in the same cycle as a matching read -> no pulse that cycle; next matching read pulses.
REQ-035 Reset asserted at REM0=1 -> after release, matching read gives no RPERR; CTL0 reads 0x0000.
REQ-036 Build without IERL78_PRTYERR_CNT_EN, NUM=1 -> 5 matching reads give 5 pulses; CTL0 reads 0x0001.

Source files
------------

// File: rtl/ierl78_prtyerr_multi.sv
// ierl78_prtyerr_multi: host-programmable parity-error injector with NCH channels.
// Each channel watches CPU read addresses and, when armed and matching, raises
// a registered RPERR pulse toward csc. An optional per-channel injection count
// is compiled in with the macro IERL78_PRTYERR_CNT_EN; without it, armed
// channels inject on every matching read.
module ierl78_prtyerr_multi #(
  parameter int NCH = 2,
  parameter int AW  = 16
) (
  input  logic          BASECK,
  input  logic          SYSRSOUTB,
  input  logic [AW-1:0] MA,
  input  logic          CPURD,
  input  logic          SVMOD,
  input  logic          FCHRAM,
  input  logic [31:0]   ICEIFA,
  input  logic [15:0]   ICEDI,
  input  logic          ICEWR,
  output logic [31:0]   ICEDOPB,
  output logic          RPERR
);

  localparam logic [31:0] BASE_ADDR = 32'h0401_0000;
  localparam logic [31:0] STAT_ADDR = 32'h0401_0100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e        st_q  [NCH];
  state_e        st_d  [NCH];
  logic [AW-1:0] adr_q [NCH];
  logic [AW-1:0] adr_d [NCH];
  logic          en_q  [NCH];
  logic          en_d  [NCH];
`ifdef IERL78_PRTYERR_CNT_EN
  logic [7:0]    num_q [NCH];
  logic [7:0]    num_d [NCH];
  logic [7:0]    rem_q [NCH];
  logic [7:0]    rem_d [NCH];
`endif
  logic [NCH-1:0] hit_q, hit_d;
  logic           rperr_q, rperr_d;

  logic [NCH-1:0] wr_adr, wr_ctl, match, take, done_vec;
  logic           wr_stat;
  // Only ICEDI[0] and [15:8] carry CTL fields; the rest is folded here.
  logic           unused_di;

  assign unused_di = ^ICEDI;
  assign wr_stat   = ICEWR && (ICEIFA == STAT_ADDR);

  // Per-channel write decode and hit qualification; a host write to the
  // channel's own ADR/CTL suppresses that channel's hit in the same cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    wr_adr = '0;
    wr_ctl = '0;
    match  = '0;
    take   = '0;
    for (int n = 0; n < NCH; n++) begin
      wr_adr[n] = ICEWR && (ICEIFA == BASE_ADDR + 32'(8 * n));
      wr_ctl[n] = ICEWR && (ICEIFA == BASE_ADDR + 32'(8 * n + 4));
      match[n]  = (st_q[n] == ST_ARMED) && CPURD && !SVMOD && !FCHRAM &&
                  (MA == adr_q[n]);
      take[n]   = match[n] && !wr_adr[n] && !wr_ctl[n];
    end
  end

  // Next-state for channel FSMs, address/control registers and sticky HIT.
  always_comb begin
    hit_d   = hit_q;
    rperr_d = |take;
    for (int n = 0; n < NCH; n++) begin
      st_d[n]  = st_q[n];
      adr_d[n] = adr_q[n];
      en_d[n]  = en_q[n];
`ifdef IERL78_PRTYERR_CNT_EN
      num_d[n] = num_q[n];
      rem_d[n] = rem_q[n];
`endif
      // A new hit wins over a simultaneous W1C so the event is never lost.
      hit_d[n] = (hit_q[n] && !(wr_stat && ICEDI[n])) || take[n];

      // Host data is 16 bits wide; wider address registers are zero-extended.
      if (wr_adr[n]) adr_d[n] = AW'(ICEDI);

      if (wr_ctl[n]) begin
        en_d[n] = ICEDI[0];
        st_d[n] = ICEDI[0] ? ST_ARMED : ST_IDLE;
`ifdef IERL78_PRTYERR_CNT_EN
        num_d[n] = ICEDI[15:8];
        rem_d[n] = ICEDI[15:8];
`endif
      end else if (take[n]) begin
`ifdef IERL78_PRTYERR_CNT_EN
        // NUM=0 means unlimited; the rem check keeps REM from wrapping.
        if (num_q[n] != 8'd0 && rem_q[n] != 8'd0) begin
          rem_d[n] = rem_q[n] - 8'd1;
          if (rem_q[n] == 8'd1) st_d[n] = ST_DONE;
        end
`endif
      end
    end
  end

  // DONE status bits exist only when the counter is compiled in.
  always_comb begin
    done_vec = '0;
`ifdef IERL78_PRTYERR_CNT_EN
    for (int n = 0; n < NCH; n++) done_vec[n] = (st_q[n] == ST_DONE);
`endif
  end

  // Host read mux; unmapped addresses return zero.
  always_comb begin
    ICEDOPB = '0;
    for (int n = 0; n < NCH; n++) begin
      if (ICEIFA == BASE_ADDR + 32'(8 * n)) ICEDOPB = 32'(adr_q[n]);
      if (ICEIFA == BASE_ADDR + 32'(8 * n + 4)) begin
`ifdef IERL78_PRTYERR_CNT_EN
        ICEDOPB = {16'h0, num_q[n], 7'h0, en_q[n]};
`else
        ICEDOPB = {31'h0, en_q[n]};
`endif
      end
    end
    if (ICEIFA == STAT_ADDR) ICEDOPB = 32'(hit_q) | (32'(done_vec) << 8);
  end

  // State registers; reset aborts any pending injection immediately.
  always_ff @(posedge BASECK or negedge SYSRSOUTB) begin
    if (!SYSRSOUTB) begin
      // NOTE: these register arrays are a handful of flops, not a RAM, so they are reset.
      for (int n = 0; n < NCH; n++) begin
        st_q[n]  <= ST_IDLE;
        adr_q[n] <= '0;
        en_q[n]  <= 1'b0;
`ifdef IERL78_PRTYERR_CNT_EN
        num_q[n] <= '0;
        rem_q[n] <= '0;
`endif
      end
      hit_q   <= '0;
      rperr_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      for (int n = 0; n < NCH; n++) begin
        st_q[n]  <= st_d[n];
        adr_q[n] <= adr_d[n];
        en_q[n]  <= en_d[n];
`ifdef IERL78_PRTYERR_CNT_EN
        num_q[n] <= num_d[n];
        rem_q[n] <= rem_d[n];
`endif
      end
      hit_q   <= hit_d;
      rperr_q <= rperr_d;
    end
  end

  assign RPERR = rperr_q;

endmodule

// File: tb/tb_ierl78_prtyerr_multi.sv
// Testbench for ierl78_prtyerr_multi (NCH=2, AW=16). Table of per-cycle
// vectors plus hand-written reset sequences; RPERR expectations go through
// a queue and are compared one cycle after the stimulus that caused them.
module tb_ierl78_prtyerr_multi;

  localparam logic [31:0] ADR0 = 32'h0401_0000;
  localparam logic [31:0] CTL0 = 32'h0401_0004;
  localparam logic [31:0] ADR1 = 32'h0401_0008;
  localparam logic [31:0] CTL1 = 32'h0401_000C;
  localparam logic [31:0] STAT = 32'h0401_0100;
  localparam logic [31:0] NONE = 32'h0401_0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ma;
  logic        cpurd, svmod, fchram, icewr;
  logic [31:0] iceifa;
  logic [15:0] icedi;
  logic [31:0] icedopb;
  logic        rperr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] ma;
    logic        rd, sv, fc, wr;
    logic [31:0] ifa;
    logic [15:0] di;
    logic        chk;
    logic [31:0] exp_do;
    logic        exp_rp;
  } vec_t;

  vec_t tbl[$];
  logic exp_q[$];
  logic last_rp;

  ierl78_prtyerr_multi #(.NCH(2), .AW(16)) dut (
    .BASECK   (clk),
    .SYSRSOUTB(rst_n),
    .MA       (ma),
    .CPURD    (cpurd),
    .SVMOD    (svmod),
    .FCHRAM   (fchram),
    .ICEIFA   (iceifa),
    .ICEDI    (icedi),
    .ICEWR    (icewr),
    .ICEDOPB  (icedopb),
    .RPERR    (rperr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] m, input logic rd, input logic sv,
                              input logic fc, input logic wr, input logic [31:0] a,
                              input logic [15:0] d, input logic chk,
                              input logic [31:0] exp_do, input logic exp_rp);
    vec_t v;
    v.ma = m; v.rd = rd; v.sv = sv; v.fc = fc; v.wr = wr;
    v.ifa = a; v.di = d; v.chk = chk; v.exp_do = exp_do; v.exp_rp = exp_rp;
    return v;
  endfunction

  // Host write, CPU idle.
  function automatic void w(input logic [31:0] a, input logic [15:0] d);
    tbl.push_back(mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, a, d, 1'b0, 32'h0, 1'b0));
  endfunction
  // CPU read at address m, expecting a hit (exp_rp) from this cycle.
  function automatic void r(input logic [15:0] m, input logic exp_rp);
    tbl.push_back(mk(m, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, exp_rp));
  endfunction
  // Host register read check.
  function automatic void q(input logic [31:0] a, input logic [31:0] exp_do);
    tbl.push_back(mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, a, 16'h0, 1'b1, exp_do, 1'b0));
  endfunction

  // One clock cycle: drive, check combinational read and the RPERR left by
  // the previous cycle, then after the edge pop and check this cycle's RPERR.
  task automatic apply(input vec_t v, input int idx);
    logic e;
    @(negedge clk);
    ma = v.ma; cpurd = v.rd; svmod = v.sv; fchram = v.fc;
    icewr = v.wr; iceifa = v.ifa; icedi = v.di;
    #1;
    if (v.chk) check($sformatf("vec%0d read 0x%08h", idx, v.ifa), icedopb, v.exp_do);
    check($sformatf("vec%0d rperr hold", idx), 32'(rperr), 32'(last_rp));
    exp_q.push_back(v.exp_rp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("vec%0d rperr", idx), 32'(rperr), 32'(e));
    last_rp = e;
  endtask

  task automatic idle_inputs();
    ma = '0; cpurd = 0; svmod = 0; fchram = 0; icewr = 0; iceifa = '0; icedi = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n   = 1'b0;
    last_rp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset rperr", 32'(rperr), 32'h0);
    iceifa = STAT; #1; check("reset stat", icedopb, 32'h0);
    iceifa = CTL0; #1; check("reset ctl0", icedopb, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table ----
    q(ADR0, 32'h0); q(ADR1, 32'h0); q(CTL1, 32'h0); q(NONE, 32'h0);
    // ch0 unlimited at 0x1234: three back-to-back hits
    w(ADR0, 16'h1234); w(CTL0, 16'h0001);
    q(ADR0, 32'h1234); q(CTL0, 32'h0001);
    r(16'h1234, 1); r(16'h1234, 1); r(16'h1234, 1); r(16'h1235, 0);
    q(STAT, 32'h0001);
    // W1C clears; W1C coinciding with a hit leaves HIT set
    w(STAT, 16'h0001); q(STAT, 32'h0);
    tbl.push_back(mk(16'h1234, 1, 0, 0, 1, STAT, 16'h0001, 1'b0, 32'h0, 1'b1));
    q(STAT, 32'h0001); w(STAT, 16'h00FF); q(STAT, 32'h0);
    // blocked by SVMOD, FCHRAM, and no CPURD
    tbl.push_back(mk(16'h1234, 1, 1, 0, 0, 32'h0, 16'h0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk(16'h1234, 1, 0, 1, 0, 32'h0, 16'h0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk(16'h1234, 0, 0, 0, 0, 32'h0, 16'h0, 1'b0, 32'h0, 1'b0));
    q(STAT, 32'h0);
    // own CTL0 / ADR0 write collides with a hit: no pulse, no HIT
    tbl.push_back(mk(16'h1234, 1, 0, 0, 1, CTL0, 16'h0001, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk(16'h1234, 1, 0, 0, 1, ADR0, 16'h1234, 1'b0, 32'h0, 1'b0));
    q(STAT, 32'h0);
    r(16'h1234, 1); q(STAT, 32'h0001);
    // another channel's CTL write does not block ch0
    tbl.push_back(mk(16'h1234, 1, 0, 0, 1, CTL1, 16'h0000, 1'b0, 32'h0, 1'b1));
    // shared address: both channels count the same read
    w(STAT, 16'h0003); w(ADR1, 16'h1234); w(CTL1, 16'h0001);
    r(16'h1234, 1); q(STAT, 32'h0003);
    w(STAT, 16'h0003);
    tbl.push_back(mk(16'h1234, 1, 0, 0, 1, CTL0, 16'h0001, 1'b0, 32'h0, 1'b1));
    q(STAT, 32'h0002);
    w(STAT, 16'h0003); w(CTL1, 16'h0000); w(CTL0, 16'h0000);
    r(16'h1234, 0); q(STAT, 32'h0);
`ifdef IERL78_PRTYERR_CNT_EN
    // ch1 NUM=2: two pulses then DONE; rearm clears DONE
    w(CTL1, 16'h0201); q(CTL1, 32'h0201);
    r(16'h1234, 1); r(16'h1234, 1); r(16'h1234, 0); r(16'h1234, 0);
    q(STAT, 32'h0202);
    w(CTL1, 16'h0101); q(STAT, 32'h0002);
    r(16'h1234, 1); r(16'h1234, 0); q(STAT, 32'h0202);
    w(CTL1, 16'h0000); w(STAT, 16'h0003); q(STAT, 32'h0);
    // leave ch0 armed with REM=1 for the reset sequence
    w(CTL0, 16'h0101); q(CTL0, 32'h0101);
`else
    // no counter: NUM ignored, every armed read injects
    w(CTL0, 16'h0101); q(CTL0, 32'h0001);
    r(16'h1234, 1); r(16'h1234, 1); r(16'h1234, 1); r(16'h1234, 1); r(16'h1234, 1);
    q(STAT, 32'h0001);
    w(STAT, 16'h0001); q(STAT, 32'h0);
`endif

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // ---- reset while ch0 is armed (REM0=1 in counter build) ----
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("midrst rperr", 32'(rperr), 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    last_rp = 1'b0;
    apply(mk(16'h1234, 1, 0, 0, 0, CTL0, 16'h0, 1'b1, 32'h0, 1'b0), 900);
    apply(mk(16'h0000, 1, 0, 0, 0, ADR0, 16'h0, 1'b1, 32'h0, 1'b0), 901);
    apply(mk(16'h1234, 1, 0, 0, 0, STAT, 16'h0, 1'b1, 32'h0, 1'b0), 902);

    // ---- reset while RPERR is high clears it asynchronously ----
    apply(mk(16'h0, 0, 0, 0, 1, ADR0, 16'h4321, 1'b0, 32'h0, 1'b0), 903);
    apply(mk(16'h0, 0, 0, 0, 1, CTL0, 16'h0001, 1'b0, 32'h0, 1'b0), 904);
    apply(mk(16'h4321, 1, 0, 0, 0, 32'h0, 16'h0, 1'b0, 32'h0, 1'b1), 905);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst rperr", 32'(rperr), 32'h0);
    iceifa = STAT; #1; check("async rst stat", icedopb, 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    last_rp = 1'b0;
    apply(mk(16'h4321, 1, 0, 0, 0, CTL0, 16'h0, 1'b1, 32'h0, 1'b0), 906);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
